// File: rtl/audio_pkg.sv
// audio_pkg: definitions shared by the tone sequencer and its phase accumulator.
//   - FSM state encoding (plain localparams so older code can keep using them)
//   - default widths
//   - note-word field layout: {inc, dur}, where inc sits above dur
//   - END_DUR: a note with this duration marks the end of the table
package audio_pkg;

    localparam int PHASE_W_DEF = 16;
    localparam int ROM_AW_DEF  = 8;
    localparam int DUR_W_DEF   = 16;
    localparam int NOTE_AW_DEF = 6;
    localparam int SAMPLE_W    = 16;

    // Note word field positions at the default widths.
    localparam int NOTE_INC_MSB = PHASE_W_DEF + DUR_W_DEF - 1;
    localparam int NOTE_INC_LSB = DUR_W_DEF;
    localparam int NOTE_DUR_MSB = DUR_W_DEF - 1;
    localparam int NOTE_DUR_LSB = 0;

    localparam int END_DUR = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH_A = 2'd1;
    localparam logic [1:0] ST_FETCH_D = 2'd2;
    localparam logic [1:0] ST_PLAY    = 2'd3;

endpackage

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: DDS phase accumulator.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : phase <= 0 (start of a new melody)
//   load_inc  : latch inc_in as the current phase increment
//   inc_in    : increment from the note table
//   advance   : phase <= phase + inc_r, wrapping modulo 2^PHASE_W
//   inc_r     : currently latched increment
//   rom_addr  : top ROM_AW bits of the registered phase
module dds_phase_acc #(
    parameter int PHASE_W = 16,
    parameter int ROM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load_inc,
    input  logic [PHASE_W-1:0] inc_in,
    input  logic               advance,
    output logic [PHASE_W-1:0] inc_r,
    output logic [ROM_AW-1:0]  rom_addr
);

    logic [PHASE_W-1:0] phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            inc_r <= '0;
        end else begin
            // A rest has inc_r == 0, so advancing leaves the phase unchanged.
            if (clear)
                phase <= '0;
            else if (advance)
                phase <= phase + inc_r;
            if (load_inc)
                inc_r <= inc_in;
        end
    end

    assign rom_addr = phase[PHASE_W-1 -: ROM_AW];

endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: walks a note table and feeds sine-ROM samples to the I2S driver.
//   clk, rst   : bit clock, synchronous active-high reset
//   start/stop : one-cycle pulses to begin playback / abort it (stop wins)
//   loop_en    : at the end of the table, restart from note 0
//   req        : driver sample request
//   sample     : sample register feeding the driver idata
//   rom_addr   : sine ROM address, rom_data: registered sine ROM output
//   note_addr  : note-table address, note_data: registered {inc, dur} word
//   busy       : not idle, done: end of a non-looping run, underrun: sticky
module tone_sequencer
    import audio_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ROM_AW  = ROM_AW_DEF,
    parameter int DUR_W   = DUR_W_DEF,
    parameter int NOTE_AW = NOTE_AW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic                     req,
    output logic [SAMPLE_W-1:0]      sample,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [SAMPLE_W-1:0]      rom_data,
    output logic [NOTE_AW-1:0]       note_addr,
    input  logic [PHASE_W+DUR_W-1:0] note_data,
    output logic                     busy,
    output logic                     done,
    output logic                     underrun
);

    logic [1:0]         state;
    logic [NOTE_AW-1:0] note_idx;
    logic [DUR_W-1:0]   dur_cnt;
    logic [PHASE_W-1:0] inc_r;
    // Set when the last table slot has finished: the next fetch is then
    // handled as an end marker instead of letting note_idx wrap to 0.
    logic               last_note;

    logic [PHASE_W-1:0] note_inc;
    logic [DUR_W-1:0]   note_dur;
    logic               is_end;
    logic               play_req;

    assign note_inc = note_data[PHASE_W+DUR_W-1:DUR_W];
    assign note_dur = note_data[DUR_W-1:0];
    assign is_end   = (note_dur == DUR_W'(END_DUR)) || last_note;
    assign play_req = (state == ST_PLAY) && req && !stop;

    dds_phase_acc #(
        .PHASE_W (PHASE_W),
        .ROM_AW  (ROM_AW)
    ) u_dds (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state == ST_IDLE) && start && !stop),
        .load_inc ((state == ST_FETCH_D) && !stop),
        .inc_in   (note_inc),
        .advance  (play_req),
        .inc_r    (inc_r),
        .rom_addr (rom_addr)
    );

    assign note_addr = note_idx;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            note_idx  <= '0;
            dur_cnt   <= '0;
            last_note <= 1'b0;
            sample    <= '0;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // Stop while idle also swallows a coincident start.
                if (state != ST_IDLE) begin
                    state  <= ST_IDLE;
                    sample <= '0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state     <= ST_FETCH_A;
                            note_idx  <= '0;
                            underrun  <= 1'b0;
                            last_note <= 1'b0;
                        end
                    end
                    ST_FETCH_A: begin
                        if (req)
                            underrun <= 1'b1;
                        state <= ST_FETCH_D;
                    end
                    ST_FETCH_D: begin
                        if (req)
                            underrun <= 1'b1;
                        last_note <= 1'b0;
                        if (is_end) begin
                            if (loop_en) begin
                                note_idx <= '0;
                                state    <= ST_FETCH_A;
                            end else begin
                                state  <= ST_IDLE;
                                done   <= 1'b1;
                                sample <= '0;
                            end
                        end else begin
                            dur_cnt <= note_dur;
                            state   <= ST_PLAY;
                        end
                    end
                    default: begin // ST_PLAY
                        if (req) begin
                            sample  <= (inc_r == '0) ? '0 : rom_data;
                            dur_cnt <= dur_cnt - DUR_W'(1);
                            if (dur_cnt == DUR_W'(1)) begin
                                state <= ST_FETCH_A;
                                if (&note_idx)
                                    last_note <= 1'b1;
                                else
                                    note_idx <= note_idx + NOTE_AW'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;

    localparam int AW  = 8;
    localparam int NAW = 6;

    logic        clk = 1'b0;
    logic        rst, start, stop, loop_en, req;
    logic [15:0] sample;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [5:0]  note_addr;
    logic [31:0] note_data;
    logic        busy, done, underrun;

    tone_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .req(req), .sample(sample), .rom_addr(rom_addr), .rom_data(rom_data),
        .note_addr(note_addr), .note_data(note_data), .busy(busy),
        .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Registered ROMs with one clock of read latency.
    logic [15:0] rom_mem  [256];
    logic [31:0] note_mem [64];
    always @(posedge clk) begin
        rom_data  <= rom_mem[rom_addr];
        note_data <= note_mem[note_addr];
    end

    typedef struct {
        logic [15:0] smp;
        logic [7:0]  addr;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    int          done_cnt = 0;
    int unsigned m_phase;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every served request presents a ROM address before the edge
    // and a new sample after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && req === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: request with no expected sample at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("rom_addr", rom_addr, e.addr);
                    @(negedge clk);
                    chk("sample", sample, e.smp);
                end
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // Reference: expand the table into one increment per sample request.
    task automatic build_list(output int unsigned incs[$]);
        incs = {};
        for (int i = 0; i < 64; i++) begin
            if (note_mem[i][15:0] == 16'd0) break;
            for (int k = 0; k < int'(note_mem[i][15:0]); k++)
                incs.push_back(note_mem[i][31:16]);
        end
    endtask

    task automatic push_expect(input int unsigned inc);
        exp_t e;
        e.addr   = m_phase[15:8];
        e.smp    = (inc == 0) ? 16'h0 : rom_mem[m_phase[15:8]];
        m_phase  = (m_phase + inc) & 32'hFFFF;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue_req();
        tick(); req = 1'b1;
        tick(); req = 1'b0;
        repeat ($urandom_range(5, 9)) tick();
    endtask

    task automatic pulse_start();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic clear_table();
        for (int i = 0; i < 64; i++) note_mem[i] = 32'h0;
    endtask

    task automatic run_seq(input bit lp, input int passes);
        int unsigned incs[$];
        int dc0;
        build_list(incs);
        loop_en = lp;
        dc0     = done_cnt;
        m_phase = 0;
        pulse_start();
        repeat (2) tick();
        mon_en = 1'b1;
        for (int p = 0; p < passes; p++)
            foreach (incs[j]) begin
                push_expect(incs[j]);
                issue_req();
            end
        chk("sb_drain", q.size(), 0);
        if (!lp) begin
            wait_idle();
            chk("done_count", done_cnt - dc0, 1);
            chk("sample_idle", sample, 0);
        end else begin
            chk("loop_no_done", done_cnt - dc0, 0);
            chk("loop_busy", busy, 1);
            tick(); stop = 1'b1;
            tick(); stop = 1'b0;
            @(negedge clk);
            chk("loop_stop_busy", busy, 0);
        end
        mon_en = 1'b0;
    endtask

    initial begin
        int dc0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; req = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'(i);
        clear_table();

        // Reset with req toggling.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 req = ~req;
        end
        req = 1'b0;
        @(negedge clk);
        chk("rst_sample", sample, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_rom_addr", rom_addr, 0);
        tick(); rst = 1'b0;

        // Single note on identity ROM.
        note_mem[0] = {16'h0100, 16'd4};
        run_seq(1'b0, 1);

        // Wrap then rest.
        clear_table();
        note_mem[0] = {16'hC000, 16'd3};
        note_mem[1] = {16'h0000, 16'd2};
        run_seq(1'b0, 1);

        // Loop.
        clear_table();
        note_mem[0] = {16'h0200, 16'd2};
        run_seq(1'b1, 3);

        // Stop during PLAY with two requests left.
        clear_table();
        note_mem[0] = {16'h0100, 16'd4};
        loop_en = 1'b0;
        m_phase = 0;
        dc0 = done_cnt;
        pulse_start();
        repeat (2) tick();
        mon_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_expect(32'h0100);
            issue_req();
        end
        mon_en = 1'b0;
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        @(negedge clk);
        chk("stop_busy", busy, 0);
        chk("stop_sample", sample, 0);
        repeat (3) tick();
        chk("stop_no_done", done_cnt - dc0, 0);

        // start and stop together from idle.
        tick(); start = 1'b1; stop = 1'b1;
        tick(); start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("startstop_busy", busy, 0);
        repeat (3) tick();
        chk("startstop_busy_later", busy, 0);

        // Underrun: request while fetching, note still plays its full length.
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'($urandom);
        clear_table();
        note_mem[0] = {16'h0300, 16'd3};
        m_phase = 0;
        dc0 = done_cnt;
        tick(); start = 1'b1;
        tick(); start = 1'b0; req = 1'b1;
        tick(); req = 1'b0;
        @(negedge clk);
        chk("underrun_set", underrun, 1);
        chk("underrun_sample", sample, 0);
        chk("underrun_rom_addr", rom_addr, 0);
        repeat (3) tick();
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_expect(32'h0300);
            issue_req();
        end
        wait_idle();
        mon_en = 1'b0;
        chk("underrun_done", done_cnt - dc0, 1);
        chk("underrun_sticky", underrun, 1);
        pulse_start();
        @(negedge clk);
        chk("underrun_cleared", underrun, 0);
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;

        // Random tables and ROM contents.
        for (int t = 0; t < 5; t++) begin
            int n;
            for (int i = 0; i < 256; i++) rom_mem[i] = 16'($urandom);
            clear_table();
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++)
                note_mem[i] = {($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                               16'($urandom_range(1, 4))};
            run_seq(t == 4, (t == 4) ? 2 : 1);
        end

        // Full table without an end marker: stops after the last slot.
        for (int i = 0; i < 64; i++) note_mem[i] = {16'($urandom), 16'd1};
        run_seq(1'b0, 1);
        chk("full_table_note_addr", note_addr, 63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Plays a melody by scheduling the shared 256-entry sine ROM and feeding samples to the I2S audio driver.
- Each note in an external note table is a phase increment plus a duration counted in samples.
- On every driver sample request, the block advances a DDS phase accumulator, addresses the sine ROM, and presents the next sample.
- Sits between the sine ROM, a note-table ROM and the audio driver's req/idata pair. Runs in the driver's bit-clock domain.

Parameters:
- PHASE_W, 16, phase accumulator width; also the increment width.
- ROM_AW, 8, sine ROM address width; rom_addr = phase[PHASE_W-1 -: ROM_AW].
- DUR_W, 16, note duration width in samples.
- NOTE_AW, 6, note-table address width.

Ports:
- clk  in  1  bit clock, same domain as the driver's req.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins playback from note 0.
- stop  in  1  one-cycle pulse; aborts playback.
- loop_en  in  1  at end of table, restart from note 0 instead of finishing.
- req  in  1  driver sample request, one-cycle pulse, spacing >= 4 clk.
- sample  out  16  signed sample to driver idata.
- rom_addr  out  ROM_AW  sine ROM address.
- rom_data  in  16  sine ROM data, registered read, 1-clk latency.
- note_addr  out  NOTE_AW  note-table address.
- note_data  in  PHASE_W+DUR_W  {inc, dur}, registered read, 1-clk latency.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a non-looping sequence ends.
- underrun  out  1  sticky; a req arrived while no note was loaded.

Behaviour:
- Reset: state IDLE; phase, note_idx, inc_r, dur_cnt = 0; sample = 0, rom_addr = 0, note_addr = 0, busy = 0, done = 0, underrun = 0.
- States: IDLE, FETCH_A, FETCH_D, PLAY.
- IDLE:
  - req ignored; sample held at 0.
  - start -> FETCH_A next cycle; phase <= 0, note_idx <= 0, underrun <= 0.
- FETCH_A: note_addr = note_idx. -> FETCH_D.
- FETCH_D:
  - Latch inc_r, dur from note_data.
  - dur == 0 is the end marker:
    - loop_en = 1 -> note_idx <= 0, go FETCH_A.
    - loop_en = 0 -> IDLE, done pulses for 1 cycle, sample <= 0.
  - Otherwise dur_cnt <= dur, go PLAY.
  - Latency: start sampled at cycle t -> PLAY at t+3.
- PLAY, on req:
  - sample <= (inc_r == 0) ? 0 : rom_data.
  - phase <= phase + inc_r, modulo 2^PHASE_W.
  - dur_cnt <= dur_cnt - 1.
  - If dur_cnt == 1: note_idx <= note_idx + 1, go FETCH_A.
  - inc_r == 0 is a rest: phase does not change, output is 0.
- rom_addr is driven from registered phase. Data for the current phase is valid 1 clk after a phase update, before the next req given spacing >= 4.
- Phase is continuous across notes; it resets only on start.
- note_idx reaching 2^NOTE_AW-1 with a non-end note: after that note, treat as end marker (same loop_en rule). Never wraps silently.
- req during FETCH_A/FETCH_D:
  - underrun <= 1.
  - sample held, phase and dur_cnt unchanged; the request is not counted toward the duration.
- stop in any non-IDLE state -> IDLE next cycle, sample <= 0, no done pulse.
- start while busy: ignored.
- start and stop in the same cycle: stop wins; state stays or becomes IDLE.
- rst mid-playback: all reset values next cycle; no done pulse.
- loop_en is sampled only at the end marker.

Decomposition:
- Shared package audio_pkg:
  - State encoding.
  - Note word field positions: INC at [PHASE_W+DUR_W-1:DUR_W], DUR at [DUR_W-1:0].
  - END_DUR = 0 constant.
  - Default widths.
- One natural sub-module, dds_phase_acc:
  - Holds phase, with clear, load-inc and advance inputs.
  - Outputs rom_addr.
- FSM, counters and output register stay in tone_sequencer.

Test Plan:
- Reset: rst high 3 clk with req toggling -> sample=0, busy=0, done=0, underrun=0, rom_addr=0.
- Table {inc=0x0100,dur=4},{end}, sine ROM = identity (rom[n]=n), req every 8 clk:
  - rom_addr steps 0,1,2,3.
  - sample = 0,1,2,3.
  - After the 4th req, FETCH of idx 1 -> done pulse once, busy=0, sample=0.
- Rest and wrap, table {inc=0xC000,dur=3},{inc=0,dur=2},{end}:
  - rom_addr 0x00, 0xC0, 0x80, then sample 0 twice.
  - Phase stays at 0x4000 during the rest.
- Loop: loop_en=1, table {inc=0x0200,dur=2},{end} -> note_addr cycles 0,1,0,1..., done never pulses, busy stays 1.
- Stop/start:
  - stop during PLAY (dur_cnt=2) -> IDLE next clk, sample=0, no done.
  - start+stop in the same cycle from IDLE -> busy stays 0.
- Underrun: req forced in FETCH_A -> underrun=1, sample unchanged, the note still plays its full dur count; next start clears underrun.
